// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
// Package  : crc16_pkg
// Brief    : Shared CRC-16 types, constants and single-bit step function.
// Revision : 1.0 - initial release
// ============================================================================
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef logic [15:0] crc16_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FIELD   = 2'd2,
        REPORT  = 2'd3
    } chk_state_e;

    // MSB-first, unreflected serial update by one bit
    function automatic crc16_t crc16_step(crc16_t crc, logic din, crc16_t poly);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Interface : crc16_frame_checker_if
// Brief     : Serial link input and verdict/status bundle of the checker.
// Revision  : 1.0 - initial release
// ============================================================================
interface crc16_frame_checker_if #(
    parameter int ERR_CNT_W = 8
);
    import crc16_pkg::*;

    logic                 data_i;
    logic                 valid_i;
    logic                 sof_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 crc_ok_o;
    logic                 crc_err_o;
    logic                 abort_o;
    crc16_t               calc_crc_o;
    crc16_t               rx_crc_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output data_i, valid_i, sof_i,
        input  busy_o, done_o, crc_ok_o, crc_err_o, abort_o,
        input  calc_crc_o, rx_crc_o, err_cnt_o
    );

    modport slave (
        input  data_i, valid_i, sof_i,
        output busy_o, done_o, crc_ok_o, crc_err_o, abort_o,
        output calc_crc_o, rx_crc_o, err_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/crc16_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : crc16_lfsr
// Brief    : Serial CRC-16 register with start-value load, step enable and hold.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_lfsr
    import crc16_pkg::*;
#(
    parameter crc16_t POLY = CRC16_POLY,
    parameter crc16_t INIT = CRC16_INIT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_en,
    input  wire logic i_din,
    output crc16_t    o_crc
);

    crc16_t r_crc;
    crc16_t w_base;

    // Load together with enable steps from INIT, so a frame's first bit is folded in
    always_comb begin
        w_base = i_load ? INIT : r_crc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= INIT;
        end else if (i_en) begin
            r_crc <= crc16_step(w_base, i_din, POLY);
        end else if (i_load) begin
            r_crc <= INIT;
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/crc16_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc16_frame_checker
// Brief    : Serial CRC-16 frame checker: payload CRC recompute, received field
//            capture and one pass/fail verdict per frame.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_frame_checker
    import crc16_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 32,
    parameter crc16_t      POLY        = CRC16_POLY,
    parameter crc16_t      INIT        = CRC16_INIT,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    crc16_frame_checker_if.slave  bus
);

    localparam int unsigned        c_CNT_W       = $clog2(PAYLOAD_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST        = c_CNT_W'(PAYLOAD_LEN - 1);
    // A one-bit payload is complete as soon as its start bit is taken
    localparam chk_state_e         c_FIRST_STATE = (PAYLOAD_LEN == 1) ? FIELD : PAYLOAD;
    localparam logic [c_CNT_W-1:0] c_FIRST_CNT   = (PAYLOAD_LEN == 1) ? '0 : c_CNT_W'(1);

    chk_state_e           r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [3:0]           r_fld_cnt;
    crc16_t               r_rx_sh;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ok;
    logic                 r_err;
    logic                 r_abort;
    crc16_t               r_calc;
    crc16_t               r_rx;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic   w_sof;
    logic   w_load;
    logic   w_en;
    logic   w_match;
    crc16_t w_crc;
    crc16_t w_rx_next;

    always_comb begin
        w_sof     = bus.valid_i & bus.sof_i;
        w_load    = w_sof & (r_state != REPORT);
        w_en      = bus.valid_i & (w_load | (r_state == PAYLOAD));
        w_rx_next = {r_rx_sh[14:0], bus.data_i};
        w_match   = (w_crc == w_rx_next);
    end

    crc16_lfsr #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_load (w_load),
        .i_en   (w_en),
        .i_din  (bus.data_i),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_fld_cnt <= '0;
            r_rx_sh   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
            r_calc    <= '0;
            r_rx      <= '0;
            r_err_cnt <= '0;
        end else begin
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sof) begin
                        r_state   <= c_FIRST_STATE;
                        r_bit_cnt <= c_FIRST_CNT;
                        r_fld_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (w_sof) begin
                        r_abort   <= 1'b1;
                        r_state   <= c_FIRST_STATE;
                        r_bit_cnt <= c_FIRST_CNT;
                        r_fld_cnt <= '0;
                    end else if (bus.valid_i) begin
                        if (r_bit_cnt == c_LAST) begin
                            r_state   <= FIELD;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                FIELD: begin
                    if (w_sof) begin
                        r_abort   <= 1'b1;
                        r_state   <= c_FIRST_STATE;
                        r_bit_cnt <= c_FIRST_CNT;
                        r_fld_cnt <= '0;
                    end else if (bus.valid_i) begin
                        r_rx_sh   <= w_rx_next;
                        r_fld_cnt <= r_fld_cnt + 4'd1;
                        // Verdict is formed on the edge taking the last CRC bit
                        if (r_fld_cnt == 4'd15) begin
                            r_state <= REPORT;
                            r_done  <= 1'b1;
                            r_ok    <= w_match;
                            r_err   <= ~w_match;
                            r_calc  <= w_crc;
                            r_rx    <= w_rx_next;
                            if (!w_match && (r_err_cnt != '1)) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.crc_ok_o   = r_ok;
    assign bus.crc_err_o  = r_err;
    assign bus.abort_o    = r_abort;
    assign bus.calc_crc_o = r_calc;
    assign bus.rx_crc_o   = r_rx;
    assign bus.err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc16_frame_checker
// Brief    : Self-checking bench for crc16_frame_checker (32- and 72-bit payloads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc16_frame_checker;
    import crc16_pkg::*;

    logic clk = 1'b0;
    logic rst, data, vld, sof, sel72;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_err32, exp_err72;
    int   done_cnt32 = 0, done_cnt72 = 0, double_cnt = 0, overlap_cnt = 0;
    logic done_q32 = 1'b0, done_q72 = 1'b0;

    always #5 clk = ~clk;

    crc16_frame_checker_if #(.ERR_CNT_W(8)) if32 ();
    crc16_frame_checker_if #(.ERR_CNT_W(8)) if72 ();

    assign if32.data_i  = data;
    assign if32.sof_i   = sof;
    assign if32.valid_i = vld & ~sel72;
    assign if72.data_i  = data;
    assign if72.sof_i   = sof;
    assign if72.valid_i = vld & sel72;

    crc16_frame_checker #(.PAYLOAD_LEN(32), .POLY(16'h8005), .INIT(16'h0000), .ERR_CNT_W(8))
        dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
    crc16_frame_checker #(.PAYLOAD_LEN(72), .POLY(16'h8005), .INIT(16'h0000), .ERR_CNT_W(8))
        dut72 (.clk_i(clk), .rst_i(rst), .bus(if72));

    // Pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (if32.done_o) done_cnt32 <= done_cnt32 + 1;
        if (if72.done_o) done_cnt72 <= done_cnt72 + 1;
        if ((if32.done_o && done_q32) || (if72.done_o && done_q72)) double_cnt <= double_cnt + 1;
        if ((if32.done_o && if32.abort_o) || (if72.done_o && if72.abort_o)) overlap_cnt <= overlap_cnt + 1;
        done_q32 <= if32.done_o;
        done_q72 <= if72.done_o;
    end

    // Reference: remainder of M(x)*x^16 divided by the full 17-bit generator
    function automatic logic [15:0] model_crc(input logic [127:0] msg, input int len);
        logic [143:0] r;
        r = {msg, 16'h0000};
        for (int i = len + 15; i >= 16; i--)
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h18005;
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] o_flags();
        return sel72 ? {3'b0, if72.busy_o, if72.done_o, if72.crc_ok_o, if72.crc_err_o, if72.abort_o}
                     : {3'b0, if32.busy_o, if32.done_o, if32.crc_ok_o, if32.crc_err_o, if32.abort_o};
    endfunction
    function automatic logic [15:0] o_calc(); return sel72 ? if72.calc_crc_o : if32.calc_crc_o; endfunction
    function automatic logic [15:0] o_rx();   return sel72 ? if72.rx_crc_o   : if32.rx_crc_o;   endfunction
    function automatic logic [7:0]  o_ecnt(); return sel72 ? if72.err_cnt_o  : if32.err_cnt_o;  endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic d, input logic s, input int gap_pct);
        for (int g = 0; g < 8 && int'($urandom_range(99, 0)) < gap_pct; g++) begin
            vld = 1'b0; data = $urandom_range(1, 0); sof = $urandom_range(1, 0);
            tick();
        end
        data = d; sof = s; vld = 1'b1;
        tick();
        vld = 1'b0; sof = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] msg, input int len, input logic [15:0] crc, input int gap_pct);
        for (int i = len - 1; i >= 0; i--) send_bit(msg[i], i == len - 1, gap_pct);
        for (int i = 15; i >= 0; i--) send_bit(crc[i], 1'b0, gap_pct);
    endtask

    // Called right after the last CRC bit was consumed
    task automatic check_verdict(input string tag, input logic ok, input logic [15:0] calc,
                                 input logic [15:0] rx, input int ecnt);
        chk({tag, ".flags"}, 32'(o_flags()), {27'b0, 1'b1, 1'b1, ok, ~ok, 1'b0});
        chk({tag, ".calc"}, 32'(o_calc()), 32'(calc));
        chk({tag, ".rx"}, 32'(o_rx()), 32'(rx));
        chk({tag, ".errcnt"}, 32'(o_ecnt()), ecnt);
        tick();
        chk({tag, ".done_drop"}, 32'(o_flags()), 32'h0);
    endtask

    initial begin
        logic [127:0] p, p2;
        logic [15:0]  c;
        logic         good;
        int           d0;

        rst = 1'b1; data = 1'b0; vld = 1'b0; sof = 1'b0; sel72 = 1'b0;
        exp_err32 = 0; exp_err72 = 0;
        repeat (3) tick();
        chk("reset.flags32", 32'(o_flags()), 0);
        chk("reset.calc32", 32'(if32.calc_crc_o), 0);
        chk("reset.rx32", 32'(if32.rx_crc_o), 0);
        chk("reset.errcnt72", 32'(if72.err_cnt_o), 0);
        rst = 1'b0;
        tick();

        send_frame(128'h0, 32, 16'h0000, 0);
        check_verdict("zero", 1'b1, 16'h0000, 16'h0000, 0);
        send_frame(128'h1, 32, 16'h8005, 0);
        check_verdict("one_good", 1'b1, 16'h8005, 16'h8005, 0);
        send_frame(128'h1, 32, 16'h8004, 0);
        exp_err32 = 1;
        check_verdict("one_bad", 1'b0, 16'h8005, 16'h8004, exp_err32);

        sel72 = 1'b1;
        p = "123456789";
        send_frame(p, 72, 16'hFEE8, 0);
        check_verdict("ascii_good", 1'b1, 16'hFEE8, 16'hFEE8, 0);
        send_frame(p, 72, 16'hFEE9, 25);
        exp_err72 = 1;
        check_verdict("ascii_bad", 1'b0, 16'hFEE8, 16'hFEE9, exp_err72);
        sel72 = 1'b0;

        for (int k = 0; k < 12; k++) begin
            p = 128'($urandom);
            good = $urandom_range(1, 0);
            c = model_crc(p, 32);
            if (!good) begin
                c = c ^ (16'h1 << $urandom_range(15, 0));
                exp_err32 = (exp_err32 < 255) ? exp_err32 + 1 : 255;
            end
            send_frame(p, 32, c, 50);
            check_verdict($sformatf("rand%0d", k), good, model_crc(p, 32), c, exp_err32);
        end

        // Restart at payload bit 10, then a complete good frame
        d0 = done_cnt32;
        p  = 128'($urandom);
        p2 = 128'($urandom);
        for (int i = 31; i > 21; i--) send_bit(p[i], i == 31, 0);
        chk("abort.busy", 32'(if32.busy_o), 1);
        send_bit(p2[31], 1'b1, 0);
        chk("abort.pulse", 32'(o_flags()), 32'h11);
        for (int i = 30; i >= 0; i--) send_bit(p2[i], 1'b0, 0);
        c = model_crc(p2, 32);
        for (int i = 15; i >= 0; i--) send_bit(c[i], 1'b0, 0);
        check_verdict("abort_frame", 1'b1, c, c, exp_err32);
        chk("abort.done_count", done_cnt32 - d0, 1);

        // Reset while receiving the CRC field
        d0 = done_cnt32;
        p  = 128'($urandom);
        c  = model_crc(p, 32);
        for (int i = 31; i >= 0; i--) send_bit(p[i], i == 31, 0);
        for (int i = 15; i > 10; i--) send_bit(c[i], 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err32 = 0;
        chk("midrst.flags", 32'(o_flags()), 0);
        chk("midrst.calc_rx", {if32.calc_crc_o, if32.rx_crc_o}, 0);
        chk("midrst.errcnt", 32'(if32.err_cnt_o), 0);
        for (int i = 10; i >= 0; i--) send_bit(c[i], 1'b0, 0);
        repeat (3) tick();
        chk("midrst.no_done", done_cnt32 - d0, 0);

        // Error counter saturation
        for (int k = 0; k < 299; k++) begin
            send_frame(128'h0, 32, 16'h0001, 0);
            exp_err32 = (exp_err32 < 255) ? exp_err32 + 1 : 255;
            if (k == 254) chk("sat.at255", 32'(if32.err_cnt_o), exp_err32);
            tick();
        end
        send_frame(128'h0, 32, 16'h0001, 0);
        check_verdict("sat_last", 1'b0, 16'h0000, 16'h0001, 255);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat.reset", 32'(if32.err_cnt_o), 0);

        tick();
        chk("single_cycle_done", double_cnt, 0);
        chk("done_abort_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc16_frame_checker.md
Name: crc16_frame_checker

Overview:
- Receive-side counterpart of the serial CRC-16 generator (poly x^16+x^15+x^2+1, 0x8005, init 0x0000, MSB-first, no reflection, no final XOR).
- Accepts a serial frame of PAYLOAD_LEN payload bits followed by the 16-bit transmitted CRC, MSB first.
- Recomputes the CRC over the payload, captures the received field, and reports one pass/fail verdict per frame.
- Sits at the serial link input, ahead of frame consumers.

Parameters:
- PAYLOAD_LEN, 32, payload bits per frame (>=1).
- POLY, 16'h8005, generator polynomial without the x^16 term.
- INIT, 16'h0000, CRC register start value.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous reset, active-high.
- data_i  in  1  serial bit.
- valid_i  in  1  data_i qualifier; bit consumed on posedge with valid_i=1.
- sof_i  in  1  start of frame; meaningful only with valid_i=1; marks first payload bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle verdict strobe.
- crc_ok_o  out  1  verdict pass; valid while done_o=1.
- crc_err_o  out  1  verdict fail; valid while done_o=1.
- abort_o  out  1  one-cycle pulse when a frame is restarted by sof_i.
- calc_crc_o  out  16  CRC computed over the last payload; held until the next frame completes.
- rx_crc_o  out  16  received CRC field; held until the next frame completes.
- err_cnt_o  out  ERR_CNT_W  count of failed frames; saturating.

Behaviour:
- Reset: synchronous, active-high, highest priority, including mid-frame. State goes to IDLE; every output is 0; CRC register is set to INIT; counters are set to 0.
- FSM states and transitions:
  - IDLE: a bit with valid_i=1 and sof_i=1 is the first payload bit. Move to PAYLOAD with bit_cnt=1. Bits without sof_i are ignored.
  - PAYLOAD: each valid bit updates the CRC: fb = crc[15]^data_i; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 0). When bit_cnt reaches PAYLOAD_LEN, move to FIELD with bit_cnt=0.
  - FIELD: each valid bit shifts into rx_sh (MSB first) while the CRC register is frozen. On the 16th bit, move to REPORT.
  - REPORT: lasts one cycle. done_o=1; crc_ok_o=(crc==rx_sh); crc_err_o=!crc_ok_o. calc_crc_o and rx_crc_o are updated here. err_cnt_o increments on fail and saturates at all-ones. Then go to IDLE.
- REPORT consumes no bit. A valid sof_i in the REPORT cycle is dropped, so the transmitter must leave at least one idle cycle between frames.
- Latency: done_o is high exactly one cycle after the posedge that consumed the last CRC bit.
- valid_i=0: full stall. State, counters and CRC register hold; no timeout.
- sof_i=1 with valid_i=1 in PAYLOAD or FIELD:
  - Abort the current frame: abort_o=1 for one cycle, no done_o, err_cnt_o unchanged.
  - The same bit restarts the frame: CRC register = INIT updated with data_i, bit_cnt=1, state PAYLOAD.
- busy_o=1 in PAYLOAD, FIELD and REPORT.
- done_o and abort_o are never high in the same cycle. Verdict outputs are registered.
- bit_cnt width is $clog2(PAYLOAD_LEN+1) and it must not wrap within a frame.

Decomposition:
- Package crc16_pkg holds:
  - CRC16_POLY = 16'h8005 and CRC16_INIT = 16'h0000;
  - typedef crc16_t (logic [15:0]);
  - state enum chk_state_e {IDLE, PAYLOAD, FIELD, REPORT};
  - function crc16_step(crc16_t crc, logic bit, crc16_t poly), shared with the generator and benches.
- One natural sub-module: crc16_lfsr. It holds the CRC register with init, enable and hold, and is reusable by the generator.

Test Plan:
- PAYLOAD_LEN=32, payload 32'h0000_0000, CRC 16'h0000 -> done_o one cycle after last bit, crc_ok_o=1, calc_crc_o=rx_crc_o=16'h0000, err_cnt_o=0.
- Payload 32'h0000_0001, CRC 16'h8005 -> crc_ok_o=1. The same frame with CRC 16'h8004 -> crc_err_o=1, err_cnt_o=1.
- PAYLOAD_LEN=72, ASCII "123456789" MSB-first per byte, CRC 16'hFEE8 -> crc_ok_o=1, calc_crc_o=16'hFEE8. With CRC 16'hFEE9 -> crc_err_o=1.
- Random payload with valid_i randomly deasserted ~50% of cycles -> verdict and calc_crc_o equal the crc16_step golden model; done_o stays a single-cycle pulse.
- sof_i asserted at payload bit 10, then a complete good frame -> abort_o one pulse; only one done_o, with crc_ok_o=1; rst_i mid-FIELD -> all outputs 0 next cycle, no done_o.
- 300 consecutive bad frames -> err_cnt_o stops at 8'hFF; rst_i -> err_cnt_o=0.
